pbit_unit: RTL and testbench

- Single probabilistic bit (p-bit) for the Ising/p-computer array.
- Takes a signed fixed-point local field z and, on each enabled clock edge, samples pbit_val = 1 with probability (1 + tanh(z))/2.
- A top-level sequencer instantiates one per spin and pulses en one spin at a time.
- z comes from the weighted-sum datapath built from the existing qmult/qadd blocks.

---
 rtl/pbit_pkg.sv | 52 +++++
 rtl/pbit_lfsr.sv | 28 ++
 rtl/pbit_unit.sv | 82 ++++++++
 tb/tb_pbit_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pbit_pkg.sv
// Shared definitions for the p-bit unit: field format, LFSR taps/seed, tanh threshold LUT.
// Used by pbit_unit (optional bias input under PBIT_BIAS_EN) and pbit_lfsr.
package pbit_pkg;

  localparam int unsigned PBIT_N = 7;
  localparam int unsigned PBIT_Q = 2;
  localparam int unsigned LFSR_W = 32;
  localparam int unsigned RND_W  = 9;

  localparam int unsigned TAP_A = 31;
  localparam int unsigned TAP_B = 21;
  localparam int unsigned TAP_C = 1;
  localparam int unsigned TAP_D = 0;

  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 32'h1;

  // round(255 * tanh(m/4)) for clamped magnitude m in quarter steps
  function automatic logic [7:0] tanh_lut(input logic [4:0] m);
    logic [7:0] t;
    case (m)
      5'd0:    t = 8'd0;
      5'd1:    t = 8'd62;
      5'd2:    t = 8'd118;
      5'd3:    t = 8'd162;
      5'd4:    t = 8'd194;
      5'd5:    t = 8'd216;
      5'd6:    t = 8'd231;
      5'd7:    t = 8'd240;
      5'd8:    t = 8'd246;
      5'd9:    t = 8'd249;
      5'd10:   t = 8'd252;
      5'd11:   t = 8'd253;
      5'd12:   t = 8'd254;
      5'd13:   t = 8'd254;
      default: t = 8'd255;
    endcase
    return t;
  endfunction

  function automatic logic is_neg(input logic [PBIT_N-1:0] v);
    return v[PBIT_N-1];
  endfunction

  function automatic logic [PBIT_N-2:0] mag(input logic [PBIT_N-1:0] v);
    return v[PBIT_N-2:0];
  endfunction

  function automatic logic is_zero(input logic [PBIT_N-1:0] v);
    return (v[PBIT_N-2:0] == '0);
  endfunction

endpackage

// File: rtl/pbit_lfsr.sv
// 32-bit Fibonacci LFSR, free-running, seeded on asynchronous active-low reset.
// A zero seed is replaced by the default seed so the register never locks up.
module pbit_lfsr
  import pbit_pkg::*;
#(
  parameter logic [LFSR_W-1:0] INIT = SEED_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [RND_W-1:0] rnd
);

  localparam logic [LFSR_W-1:0] SEED = (INIT == '0) ? SEED_DEFAULT : INIT;

  logic [LFSR_W-1:0] state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= SEED;
    end else begin
      state <= {state[LFSR_W-2:0],
                state[TAP_A] ^ state[TAP_B] ^ state[TAP_C] ^ state[TAP_D]};
    end
  end

  assign rnd = state[RND_W-1:0];

endmodule

// File: rtl/pbit_unit.sv
// Probabilistic bit: samples pbit_val = 1 with probability (1 + tanh(z))/2 on each en pulse.
// Define PBIT_BIAS_EN to add a sign-magnitude bias input h summed into the field.
module pbit_unit
  import pbit_pkg::*;
#(
  parameter int unsigned       N    = PBIT_N,
  parameter int unsigned       Q    = PBIT_Q,
  parameter logic [LFSR_W-1:0] INIT = 32'd1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  input  logic [N-1:0] z,
`ifdef PBIT_BIAS_EN
  input  logic [N-1:0] h,
`endif
  output logic         pbit_val
);

  if (N != PBIT_N || Q != PBIT_Q) begin : g_cfg_chk
    $error("pbit_unit: threshold LUT is built for N=7, Q=2");
  end

  logic [RND_W-1:0] rnd;

  pbit_lfsr #(.INIT(INIT)) u_lfsr (
    .CLK (CLK),
    .RST (RST),
    .rnd (rnd)
  );

  logic [N-1:0] zb;

`ifdef PBIT_BIAS_EN
  logic [N-2:0] a_m;
  logic [N-2:0] b_m;
  logic [N-1:0] sum;

  assign a_m = z[N-2:0];
  assign b_m = h[N-2:0];

  // Sign-magnitude add: like signs saturate, unlike signs keep the larger operand's sign
  always_comb begin
    sum = {1'b0, a_m} + {1'b0, b_m};
    zb  = z;
    if (z[N-1] == h[N-1]) begin
      zb = {z[N-1], (sum[N-1] ? {(N-1){1'b1}} : sum[N-2:0])};
    end else if (a_m >= b_m) begin
      zb = {z[N-1], a_m - b_m};
    end else begin
      zb = {h[N-1], b_m - a_m};
    end
  end
`else
  assign zb = z;
`endif

  logic [N-2:0] m;
  logic         neg;
  logic [4:0]   magc;
  logic [7:0]   thr;
  logic [9:0]   lim;
  logic         draw;

  always_comb begin
    m    = mag(zb);
    neg  = is_neg(zb) && !is_zero(zb);
    magc = (m > (N-1)'(31)) ? 5'd31 : m[4:0];
    thr  = tanh_lut(magc);
    lim  = neg ? (10'd256 - {2'b00, thr}) : (10'd256 + {2'b00, thr});
    draw = ({1'b0, rnd} < lim);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pbit_val <= 1'b0;
    end else if (en) begin
      pbit_val <= draw;
    end
  end

endmodule

// File: tb/tb_pbit_unit.sv
// Scoreboard bench for pbit_unit: stimulus pushes model predictions, a monitor pops and compares.
`timescale 1ns/1ps
module tb_pbit_unit;

  localparam logic [31:0] SEED_A = 32'd56878;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       en  = 1'b0;
  logic [6:0] z   = '0;
  logic [6:0] h   = '0;
  logic       pv_a;
  logic       pv_b;

  always #5 CLK = ~CLK;

  pbit_unit #(.N(7), .Q(2), .INIT(SEED_A)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .en       (en),
    .z        (z),
`ifdef PBIT_BIAS_EN
    .h        (h),
`endif
    .pbit_val (pv_a)
  );

  pbit_unit #(.N(7), .Q(2), .INIT(32'd0)) dut_z (
    .CLK      (CLK),
    .RST      (RST),
    .en       (en),
    .z        (z),
`ifdef PBIT_BIAS_EN
    .h        (h),
`endif
    .pbit_val (pv_b)
  );

  // Reference model: one LFSR seeded with SEED_A, one with 1 (what INIT=0 must behave as)
  logic [31:0] m_lfsr_a;
  logic [31:0] m_lfsr_b;
  int          thr_tab [32];

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb};
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_lfsr_a <= SEED_A;
      m_lfsr_b <= 32'd1;
    end else begin
      m_lfsr_a <= lfsr_next(m_lfsr_a);
      m_lfsr_b <= lfsr_next(m_lfsr_b);
    end
  end

  function automatic logic model_draw(input logic [31:0] s, input logic [6:0] zz,
                                      input logic [6:0] hh);
    int v, mg, t, lim, u;
    v = (zz[6] ? -int'(zz[5:0]) : int'(zz[5:0])) + (hh[6] ? -int'(hh[5:0]) : int'(hh[5:0]));
    if (v > 63)  v = 63;
    if (v < -63) v = -63;
    mg = (v < 0) ? -v : v;
    if (mg > 31) mg = 31;
    t   = thr_tab[mg];
    lim = (v < 0) ? 256 - t : 256 + t;
    u   = int'(s[8:0]);
    return (u < lim);
  endfunction

  typedef struct {
    logic  ea;
    logic  eb;
    logic  tally;
    string tag;
  } exp_t;

  exp_t  sbq[$];
  logic  ep_a = 1'b0;
  logic  ep_b = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    ones  = 0;
  logic  bits_q[$];
  logic  first_bits[$];

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0b expected=%0b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: actual=%0d expected in [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  // Monitor: pbit_val is presented every edge; pop one prediction per edge that has one
  initial begin
    exp_t it;
    forever begin
      @(posedge CLK);
      #1;
      if (sbq.size() > 0) begin
        it = sbq.pop_front();
        check_bit({it.tag, "_a"}, pv_a, it.ea);
        check_bit({it.tag, "_zseed"}, pv_b, it.eb);
        if (it.tally) begin
          if (pv_a) ones++;
          bits_q.push_back(pv_a);
        end
      end
    end
  end

  task automatic step(input logic e, input logic [6:0] zz, input logic tally, input string tag);
    exp_t it;
    @(negedge CLK);
    en = e;
    z  = zz;
    if (!RST) begin
      ep_a = 1'b0;
      ep_b = 1'b0;
    end else if (e) begin
      ep_a = model_draw(m_lfsr_a, zz, h);
      ep_b = model_draw(m_lfsr_b, zz, h);
    end
    it.ea    = ep_a;
    it.eb    = ep_b;
    it.tally = tally;
    it.tag   = tag;
    sbq.push_back(it);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    en  = 1'b0;
    RST = 1'b1;
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge CLK);
    RST  = 1'b0;
    ep_a = 1'b0;
    ep_b = 1'b0;
    for (int unsigned i = 0; i < n; i++) step(1'b1, 7'b0011111, 1'b0, "reset");
    release_reset();
  endtask

  task automatic run(input int unsigned n, input logic [6:0] zz, input string tag);
    ones = 0;
    bits_q.delete();
    for (int unsigned i = 0; i < n; i++) step(1'b1, zz, 1'b1, tag);
    @(posedge CLK);
    #2;
  endtask

  task automatic drive_high(input string tag);
    for (int unsigned i = 0; i < 40 && ep_a != 1'b1; i++) step(1'b1, 7'b0011111, 1'b0, tag);
  endtask

  initial begin
    int diff;
    logic       r_en;
    logic [6:0] r_z;
    for (int i = 0; i < 32; i++) thr_tab[i] = $rtoi(255.0 * $tanh(real'(i) / 4.0) + 0.5);

    // Reset held with en active and a strong positive field
    do_reset(10);
    #1;
    check_vec("init_seed_a", dut.u_lfsr.state, SEED_A);
    check_vec("init_seed_zero", dut_z.u_lfsr.state, 32'd1);

    // Hold: pbit_val frozen while en = 0, LFSR keeps running
    drive_high("set_high");
    for (int unsigned i = 0; i < 100; i++)
      step(1'b0, (i[0] ? 7'b0011111 : 7'b1011111), 1'b0, "hold");
    @(negedge CLK);
    #1;
    check_vec("lfsr_advance", dut.u_lfsr.state, m_lfsr_a);

    // Zero field, positive and negative zero, identical streams from reset
    do_reset(2);
    run(4096, 7'b0000000, "zero_pos");
    check_rng("ones_zero_pos", ones, 1843, 2253);
    first_bits = bits_q;
    do_reset(2);
    run(4096, 7'b1000000, "zero_neg");
    check_rng("ones_zero_neg", ones, 1843, 2253);
    diff = 0;
    for (int i = 0; i < 4096; i++)
      if (i >= first_bits.size() || i >= bits_q.size() || first_bits[i] !== bits_q[i]) diff++;
    check_rng("zero_streams_differ", diff, 0, 0);

    // Unit field
    do_reset(2);
    run(4096, 7'b0000100, "unit_pos");
    check_rng("ones_unit_pos", ones, 3440, 3760);
    do_reset(2);
    run(4096, 7'b1000100, "unit_neg");
    check_rng("ones_unit_neg", ones, 336, 656);

    // Saturation and clamp
    do_reset(2);
    run(4096, 7'b0011111, "sat_pos");
    check_rng("ones_sat_pos", ones, 4070, 4096);
    do_reset(2);
    run(4096, 7'b1100000, "sat_neg");
    check_rng("ones_sat_neg", ones, 0, 26);
    do_reset(2);
    run(4096, 7'b0111111, "sat_max");
    check_rng("ones_sat_max", ones, 4070, 4096);

`ifdef PBIT_BIAS_EN
    // Bias cancels field: behaves as zero field
    h = 7'b1000100;
    do_reset(2);
    run(4096, 7'b0000100, "bias_cancel");
    check_rng("ones_bias_cancel", ones, 1843, 2253);
    h = 7'b0000000;
`endif

    // Asynchronous reset mid-operation clears and reseeds immediately
    do_reset(2);
    drive_high("pre_async");
    @(posedge CLK);
    #3;
    RST  = 1'b0;
    ep_a = 1'b0;
    ep_b = 1'b0;
    #1;
    check_bit("async_clear", pv_a, 1'b0);
    check_vec("async_reseed", dut.u_lfsr.state, SEED_A);
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 7'b0011111, 1'b0, "in_reset");
    release_reset();

    // Golden: random field and enable, bit-exact against the model
    for (int unsigned i = 0; i < 10000; i++) begin
      r_en = 1'($urandom_range(0, 1));
      r_z  = 7'($urandom_range(0, 127));
`ifdef PBIT_BIAS_EN
      h = 7'($urandom_range(0, 127));
`endif
      step(r_en, r_z, 1'b0, "golden");
    end
    @(posedge CLK);
    #2;
    check_rng("queue_drained", sbq.size(), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
